regfile_param: RTL and testbench

Parametrised, second-generation integer register file for the single-cycle RISC-V core. It sits between decode and the ALU/writeback path. It provides two asynchronous read ports, one synchronous write port, and a hardwired-zero entry 0. Beyond the basic register file, it adds optional write-to-read bypass, a sequenced post-reset clear with a `busy` flag, and a registered debug read port for the FPGA board readout.

---
 rtl/regfile_param.sv | 101 ++++++++++
 tb/tb_regfile_param.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Integer register file: two async read ports, one sync write port, hardwired x0,
// optional write-to-read bypass, post-reset clear sequencer and registered debug read.
module regfile_param #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int BYPASS     = 1,
    parameter int CLR_ON_RST = 1
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            cpu_enable,
    input  logic [AW-1:0]   RA_1,
    input  logic [AW-1:0]   RA_2,
    input  logic [AW-1:0]   RA_3,
    input  logic            WE,
    input  logic [XLEN-1:0] WD_3,
    output logic [XLEN-1:0] RD_1,
    output logic [XLEN-1:0] RD_2,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic            busy
);
    localparam int NREGS = 2 ** AW;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   clr_ptr;
    logic [AW-1:0]   clr_ptr_nxt;
    logic            clr_we;
    logic            wr_en;
    logic [XLEN-1:0] dbg_nxt;
    logic [XLEN-1:0] entry [NREGS];

    // Sequencer and core write path are exclusive by state; Rst drops both.
    assign clr_we = (state == CLEAR) && !Rst;
    assign wr_en  = (state == RUN) && !Rst && WE && cpu_enable && (RA_3 != '0);
    assign busy   = (state == CLEAR);

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        if (state == CLEAR) begin
            if (&clr_ptr) begin
                state_nxt = RUN;
            end else begin
                clr_ptr_nxt = clr_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= (CLR_ON_RST != 0) ? CLEAR : RUN;
            clr_ptr  <= AW'(1);
            dbg_data <= '0;
        end else begin
            state    <= state_nxt;
            clr_ptr  <= clr_ptr_nxt;
            dbg_data <= dbg_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        if (clr_we) begin
            entry[clr_ptr] <= '0;
        end else if (wr_en) begin
            entry[RA_3] <= WD_3;
        end
    end

    // Debug path sees stored contents only, also while clearing.
    always_comb begin
        dbg_nxt = '0;
        if (dbg_addr != '0) begin
            dbg_nxt = entry[dbg_addr];
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        logic [XLEN-1:0] val;
        val = '0;
        if (!busy && (addr != '0)) begin
            if ((BYPASS != 0) && wr_en && (RA_3 == addr)) begin
                val = WD_3;
            end else begin
                val = entry[addr];
            end
        end
        return val;
    endfunction

    always_comb begin
        RD_1 = read_port(RA_1);
        RD_2 = read_port(RA_2);
    end
endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: clear sequencing, read/write, bypass on/off, stall, debug port.
module tb_regfile_param;
    logic        clk;
    logic        rst;
    logic        cpu_enable;
    logic [4:0]  ra1, ra2, ra3, dbg_addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd1, rd2, dbg_data;
    logic        busy;
    logic [31:0] nb_rd1, nb_rd2, nb_dbg_data;
    logic        nb_busy;

    int checks   = 0;
    int failures = 0;

    regfile_param #(.BYPASS(1)) u_dut (
        .Clk(clk), .Rst(rst), .cpu_enable(cpu_enable),
        .RA_1(ra1), .RA_2(ra2), .RA_3(ra3), .WE(we), .WD_3(wd),
        .RD_1(rd1), .RD_2(rd2), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy)
    );

    regfile_param #(.BYPASS(0)) u_nobyp (
        .Clk(clk), .Rst(rst), .cpu_enable(cpu_enable),
        .RA_1(ra1), .RA_2(ra2), .RA_3(ra3), .WE(we), .WD_3(wd),
        .RD_1(nb_rd1), .RD_2(nb_rd2), .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data), .busy(nb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        en;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  ra3;
        logic [31:0] wd;
        logic [4:0]  dbga;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] edbg;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        we  = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts negedge samples with busy high, starting just after reset release.
    task automatic count_busy(output int cnt, input logic watch_dbg);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            if (watch_dbg && cnt == 2) chk("dbg_during_clear", dbg_data, 32'hDEADBEEF);
            if (watch_dbg) chk("rd1_forced_zero_busy", rd1, 32'h0);
            @(negedge clk);
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        ra3 = a; wd = d; we = 1'b1; cpu_enable = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    initial begin
        int cnt;
        rst = 1'b0; cpu_enable = 1'b0; we = 1'b0;
        ra1 = '0; ra2 = '0; ra3 = '0; wd = '0; dbg_addr = '0;

        // Power-up clear, with a write attempted while busy
        do_reset(2);
        chk("reset_busy", {31'b0, busy}, 32'h1);
        chk("reset_dbg", dbg_data, 32'h0);
        we = 1'b1; cpu_enable = 1'b1; ra3 = 5'd3; wd = 32'h77777777;
        count_busy(cnt, 1'b0);
        we = 1'b0;
        chk("busy_len_first", cnt, 32'd31);
        ra1 = 5'd3;
        #1;
        chk("no_write_while_busy", rd1, 32'h0);

        // Preload, then reset and clear
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'hDEADBEEF);
        ra1 = 5'd17;
        #1;
        chk("preload_x17", rd1, 32'hDEADBEEF);
        do_reset(2);
        ra1 = 5'd31; dbg_addr = 5'd31;
        count_busy(cnt, 1'b1);
        chk("busy_len_preload", cnt, 32'd31);
        chk("busy_low_after", {31'b0, busy}, 32'h0);

        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(i); dbg_addr = 5'(i);
            #1;
            chk("sweep_rd1", rd1, 32'h0);
            chk("sweep_rd2", rd2, 32'h0);
            @(posedge clk);
            #1;
            chk("sweep_dbg", dbg_data, 32'h0);
            @(negedge clk);
        end

        //            we    en    ra1 ra2 ra3 wd            dbga e1            e2            n1            n2            edbg
        vecs[0]  = '{1'b1, 1'b1, 5,  0,  5,  32'h12345678, 5,  32'h12345678, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1'b0, 1'b1, 5,  5,  0,  32'h0,        5,  32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[2]  = '{1'b1, 1'b1, 0,  0,  0,  32'hFFFFFFFF, 0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0};
        vecs[3]  = '{1'b1, 1'b1, 7,  7,  7,  32'hA5A5A5A5, 7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        32'h0,        32'h0};
        vecs[4]  = '{1'b0, 1'b1, 7,  7,  0,  32'h0,        7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[5]  = '{1'b1, 1'b0, 9,  5,  9,  32'h00000055, 9,  32'h0,        32'h12345678, 32'h0,        32'h12345678, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 9,  7,  0,  32'h0,        9,  32'h0,        32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 31, 5,  31, 32'h0BADF00D, 31, 32'h0BADF00D, 32'h12345678, 32'h0,        32'h12345678, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 31, 31, 0,  32'h0,        31, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D};
        vecs[9]  = '{1'b0, 1'b1, 0,  31, 0,  32'h0,        0,  32'h0,        32'h0BADF00D, 32'h0,        32'h0BADF00D, 32'h0};
        vecs[10] = '{1'b1, 1'b1, 5,  5,  5,  32'hCAFEF00D, 5,  32'hCAFEF00D, 32'hCAFEF00D, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[11] = '{1'b0, 1'b1, 5,  0,  0,  32'h0,        5,  32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'h0,        32'hCAFEF00D};

        for (int i = 0; i < 12; i++) begin
            we = vecs[i].we; cpu_enable = vecs[i].en; ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
            ra3 = vecs[i].ra3; wd = vecs[i].wd; dbg_addr = vecs[i].dbga;
            #1;
            chk($sformatf("vec%0d_rd1", i), rd1, vecs[i].e1);
            chk($sformatf("vec%0d_rd2", i), rd2, vecs[i].e2);
            chk($sformatf("vec%0d_nb_rd1", i), nb_rd1, vecs[i].n1);
            chk($sformatf("vec%0d_nb_rd2", i), nb_rd2, vecs[i].n2);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_dbg", i), dbg_data, vecs[i].edbg);
            chk($sformatf("vec%0d_nb_dbg", i), nb_dbg_data, vecs[i].edbg);
            @(negedge clk);
        end
        we = 1'b0;

        // Write presented together with Rst is dropped
        rst = 1'b1; we = 1'b1; cpu_enable = 1'b1; ra3 = 5'd12; wd = 32'h13579BDF;
        @(negedge clk);
        we = 1'b0;
        rst = 1'b0;
        count_busy(cnt, 1'b0);
        ra1 = 5'd12;
        #1;
        chk("write_with_rst_dropped", rd1, 32'h0);

        // Reset while clr_ptr == 10 restarts the whole clear
        do_reset(1);
        repeat (9) @(negedge clk);
        chk("busy_before_midclear_rst", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("busy_during_midclear_rst", {31'b0, busy}, 32'h1);
        rst = 1'b0;
        count_busy(cnt, 1'b0);
        chk("busy_len_restart", cnt, 32'd31);
        chk("nb_busy_done", {31'b0, nb_busy}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
